char_motion_ctrl: RTL and testbench
===================================

Name: char_motion_ctrl

Overview:
Parametrised per-player motion controller for the platformer; one instance per character (blue, red, ...).
- Converts key levels and four-side collision flags into position, signed vertical velocity and animation status.
- Updates once per frame tick using a GROUND/RISE/FALL state machine with gravity, terminal velocity, variable jump height and screen clamping.
- Sits between the keyboard decoder / collision detector and the sprite renderer.

Parameters:
X_W, 10, x position width
Y_W, 9, y position width
V_W, 9, signed vertical velocity width (two's complement; positive = upward)
GRAVITY, 1, velocity decrement per tick while airborne
JUMP_V, 14, initial upward velocity on jump
MAX_FALL, 14, terminal downward speed magnitude
WALK_STEP, 1, horizontal pixels per tick
X_INIT, 0, reset/respawn x
Y_INIT, 0, reset/respawn y
X_MAX, 639, rightmost legal x
Y_MAX, 479, lowest legal y (screen y grows downward)
COYOTE_TICKS, 4, grace ticks; only used with COYOTE_TIME_EN

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
frame_tick  input  1  one-cycle update strobe
move_left  input  1  left key level
move_right  input  1  right key level
jump  input  1  jump key level
coll_up  input  1  solid directly above head
coll_down  input  1  standing on solid
coll_left  input  1  solid immediately left
coll_right  input  1  solid immediately right
respawn  input  1  synchronous respawn request
x_pos  output  X_W  current x
y_pos  output  Y_W  current y
v_speed  output  V_W  signed vertical velocity
state  output  2  00 GROUND, 01 RISE, 10 FALL
facing_left  output  1  last horizontal direction
walking  output  1  x changed on last tick
airborne  output  1  state != GROUND

Behaviour:
- Reset (async, rst_n=0): x_pos=X_INIT, y_pos=Y_INIT, v_speed=0, state=FALL, facing_left=0, walking=0, jump_armed=1.
- respawn=1 on any clk edge, regardless of frame_tick, applies the same values as reset. respawn has priority over frame_tick in the same cycle.
- Without frame_tick, all registers hold. All outputs are registered; each update is visible the cycle after the tick.

Horizontal, per tick:
- move_left XOR move_right selects direction; both or neither = no move, walking=0, facing_left held.
- facing_left follows the selected direction even when blocked.
- Left move: x -= WALK_STEP unless coll_left; saturate at 0.
- Right move: x += WALK_STEP unless coll_right; saturate at X_MAX.
- walking=1 only if x actually changed.

Jump arming:
- jump_armed clears when a jump launches.
- jump_armed sets on any tick with jump=0.
- Holding jump never auto-repeats.

Vertical states, per tick:
- GROUND: v=0, y held.
  - jump & jump_armed & !coll_up → RISE, v=JUMP_V, y-=JUMP_V.
  - else !coll_down → FALL, v=0, y held.
- RISE:
  - coll_up → FALL, v=0, y held (head bump).
  - else !jump → FALL, v=0, y held (early release cuts the jump).
  - else v_new = v-GRAVITY; y -= v_new; v_new<=0 → FALL.
- FALL:
  - coll_down → GROUND, v=0, y held.
  - else v_new = max(v-GRAVITY, -MAX_FALL); y -= v_new.
- y saturates to [0, Y_MAX].
- Reaching Y_MAX while in FALL does not force GROUND; only coll_down lands.
- Arithmetic is done at V_W+1 / Y_W+1 bits before the clamp; no wrap-around is permitted.
- Horizontal and vertical updates are independent and occur in the same tick.

Optional Feature:
COYOTE_TIME_EN:
- Defined: a counter loads COYOTE_TICKS on the GROUND→FALL walk-off transition and decrements each tick in FALL. While it is nonzero, jump & jump_armed & !coll_up launches exactly as from GROUND and clears the counter. The counter clears on landing, respawn and reset.
- Undefined: no counter exists; jumps launch only from GROUND.

Test Plan:
- Reset, coll_down=1, one tick → state=GROUND, v_speed=0, x_pos=0, y_pos=0.
- Grounded at y=300, jump held, coll_* =0 after launch → ticks give y=286,273,...; state=FALL with v=0 after 14 ticks; peak y=195; no second launch until jump released.
- Same jump, jump released on tick 3 → state=FALL, v_speed=0, y_pos=261 held that tick.
- Free fall from y=100, v=0 → v_speed -1,-2,…,-14 then constant -14; y_pos=205 after 14 ticks, 219 after 15; coll_down → GROUND, v=0.
- x=639, move_right → x stays 639, walking=0, facing_left=0; move_left+move_right → no move; move_left with coll_left → x held, facing_left=1.
- With COYOTE_TIME_EN: walk off a ledge, jump on fall tick 3 → RISE, v_speed=14. Same stimulus on tick 5 → no launch.

Source files
------------

// File: rtl/char_motion_ctrl.sv
// Per-character motion controller: keys + 4-side collision -> position, signed vertical speed, animation status.
// Latency: every update is registered and visible the cycle after frame_tick; respawn acts on the next clk edge.
// Backpressure: none; frame_tick is a one-cycle strobe and is always accepted. Optional macro: COYOTE_TIME_EN.
module char_motion_ctrl #(
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int V_W          = 9,
    parameter int GRAVITY      = 1,
    parameter int JUMP_V       = 14,
    parameter int MAX_FALL     = 14,
    parameter int WALK_STEP    = 1,
    parameter int X_INIT       = 0,
    parameter int Y_INIT       = 0,
    parameter int X_MAX        = 639,
    parameter int Y_MAX        = 479,
    parameter int COYOTE_TICKS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_tick,
    input  logic                  move_left,
    input  logic                  move_right,
    input  logic                  jump,
    input  logic                  coll_up,
    input  logic                  coll_down,
    input  logic                  coll_left,
    input  logic                  coll_right,
    input  logic                  respawn,
    output logic [X_W-1:0]        x_pos,
    output logic [Y_W-1:0]        y_pos,
    output logic signed [V_W-1:0] v_speed,
    output logic [1:0]            state,
    output logic                  facing_left,
    output logic                  walking,
    output logic                  airborne
);

    typedef enum logic [1:0] {
        ST_GROUND = 2'b00,
        ST_RISE   = 2'b01,
        ST_FALL   = 2'b10
    } state_t;

    // Vertical position math runs wide enough that y - v can never wrap before the clamp.
    localparam int SW = ((Y_W > V_W) ? Y_W : V_W) + 2;

    localparam logic [X_W-1:0]        X_INIT_C = X_W'(X_INIT);
    localparam logic [X_W-1:0]        X_MAX_C  = X_W'(X_MAX);
    localparam logic [X_W:0]          X_MAX_W  = (X_W+1)'(X_MAX);
    localparam logic [X_W:0]          STEP_W   = (X_W+1)'(WALK_STEP);
    localparam logic [Y_W-1:0]        Y_INIT_C = Y_W'(Y_INIT);
    localparam logic [Y_W-1:0]        Y_MAX_C  = Y_W'(Y_MAX);
    localparam logic signed [SW-1:0]  Y_MAX_S  = SW'(Y_MAX);
    localparam logic signed [V_W:0]   GRAV_W   = (V_W+1)'(GRAVITY);
    localparam logic signed [V_W:0]   JUMP_W   = (V_W+1)'(JUMP_V);
    localparam logic signed [V_W-1:0] JUMP_N   = V_W'(JUMP_V);
    localparam logic signed [V_W:0]   NEG_MAX  = (V_W+1)'(-MAX_FALL);

    // Speeds must fit the signed velocity register; the grace period must be at least one tick.
    generate
        if (COYOTE_TICKS < 1 || JUMP_V >= 2**(V_W-1) || MAX_FALL >= 2**(V_W-1)) begin : g_param_check
            $error("char_motion_ctrl: parameter out of range");
        end
    endgenerate

    logic [X_W-1:0]        x_q, x_n;
    logic [Y_W-1:0]        y_q, y_n;
    logic signed [V_W-1:0] v_q, v_n;
    state_t                st_q, st_n;
    logic                  face_q, face_n;
    logic                  walk_q, walk_n;
    logic                  armed_q, armed_n;

    logic                  can_jump;
    logic                  launch;
    logic                  coyote_ok;
    logic signed [V_W:0]   v_ext;
    logic signed [V_W:0]   v_dec;
    logic signed [V_W:0]   v_fall;
    logic signed [V_W:0]   dy;
    logic signed [SW-1:0]  y_sum;
    logic [X_W:0]          x_ext;
    logic [X_W:0]          x_dec;
    logic [X_W:0]          x_inc;
    logic [X_W:0]          x_tgt;
    logic                  dir_left;
    logic                  dir_right;

    assign can_jump = jump && armed_q && !coll_up;
    assign v_ext    = {v_q[V_W-1], v_q};
    assign v_dec    = v_ext - GRAV_W;
    assign v_fall   = (v_dec < NEG_MAX) ? NEG_MAX : v_dec;

`ifdef COYOTE_TIME_EN
    localparam int CW = $clog2(COYOTE_TICKS + 1);
    localparam logic [CW-1:0] COY_LOAD = CW'(COYOTE_TICKS);

    logic [CW-1:0] coy_q, coy_n;

    assign coyote_ok = (coy_q != '0);

    // Grace counter: loads on walk-off, counts down while falling, clears on any other outcome.
    always_comb begin
        coy_n = '0;
        if (st_q == ST_GROUND && st_n == ST_FALL) begin
            coy_n = COY_LOAD;
        end else if (st_q == ST_FALL && st_n == ST_FALL && coy_q != '0) begin
            coy_n = coy_q - 1'b1;
        end
    end

    // Grace counter register; respawn behaves like reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coy_q <= '0;
        end else if (respawn) begin
            coy_q <= '0;
        end else if (frame_tick) begin
            coy_q <= coy_n;
        end
    end
`else
    assign coyote_ok = 1'b0;
`endif

    // Horizontal: one direction only when exactly one key is down; blocked moves still turn the sprite.
    always_comb begin
        dir_left  = move_left && !move_right;
        dir_right = move_right && !move_left;
        x_ext     = {1'b0, x_q};
        x_dec     = (x_ext < STEP_W) ? '0 : (x_ext - STEP_W);
        x_inc     = x_ext + STEP_W;
        x_tgt     = x_ext;
        face_n    = face_q;
        if (dir_left) begin
            face_n = 1'b1;
            if (!coll_left) x_tgt = x_dec;
        end else if (dir_right) begin
            face_n = 1'b0;
            if (!coll_right) x_tgt = x_inc;
        end
        x_n    = (x_tgt > X_MAX_W) ? X_MAX_C : x_tgt[X_W-1:0];
        walk_n = (x_n != x_q);
    end

    // Vertical state machine: picks next state, next velocity and the displacement dy applied to y.
    always_comb begin
        st_n    = st_q;
        v_n     = v_q;
        dy      = '0;
        launch  = 1'b0;
        armed_n = armed_q;
        case (st_q)
            ST_GROUND: begin
                v_n = '0;
                if (can_jump) begin
                    launch = 1'b1;
                end else if (!coll_down) begin
                    st_n = ST_FALL;
                end
            end
            ST_RISE: begin
                if (coll_up || !jump) begin
                    st_n = ST_FALL;
                    v_n  = '0;
                end else begin
                    v_n = v_dec[V_W-1:0];
                    dy  = v_dec;
                    if (v_dec[V_W] || v_dec == '0) st_n = ST_FALL;
                end
            end
            ST_FALL: begin
                if (coll_down) begin
                    st_n = ST_GROUND;
                    v_n  = '0;
                end else if (coyote_ok && can_jump) begin
                    launch = 1'b1;
                end else begin
                    v_n = v_fall[V_W-1:0];
                    dy  = v_fall;
                end
            end
            default: begin
                st_n = ST_FALL;
                v_n  = '0;
            end
        endcase
        // A launch overrides whatever the state arm chose; releasing the key re-arms.
        if (launch) begin
            st_n    = ST_RISE;
            v_n     = JUMP_N;
            dy      = JUMP_W;
            armed_n = 1'b0;
        end else if (!jump) begin
            armed_n = 1'b1;
        end
    end

    // Screen y grows downward, so upward velocity subtracts; result clamped to [0, Y_MAX].
    always_comb begin
        y_sum = $signed({{(SW-Y_W){1'b0}}, y_q}) - $signed({{(SW-V_W-1){dy[V_W]}}, dy});
        if (y_sum[SW-1]) begin
            y_n = '0;
        end else if (y_sum > Y_MAX_S) begin
            y_n = Y_MAX_C;
        end else begin
            y_n = y_sum[Y_W-1:0];
        end
    end

    // State registers: respawn restores the reset image and beats a same-cycle frame_tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= X_INIT_C;
            y_q     <= Y_INIT_C;
            v_q     <= '0;
            st_q    <= ST_FALL;
            face_q  <= 1'b0;
            walk_q  <= 1'b0;
            armed_q <= 1'b1;
        end else if (respawn) begin
            x_q     <= X_INIT_C;
            y_q     <= Y_INIT_C;
            v_q     <= '0;
            st_q    <= ST_FALL;
            face_q  <= 1'b0;
            walk_q  <= 1'b0;
            armed_q <= 1'b1;
        end else if (frame_tick) begin
            x_q     <= x_n;
            y_q     <= y_n;
            v_q     <= v_n;
            st_q    <= st_n;
            face_q  <= face_n;
            walk_q  <= walk_n;
            armed_q <= armed_n;
        end
    end

    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign v_speed     = v_q;
    assign state       = st_q;
    assign facing_left = face_q;
    assign walking     = walk_q;
    assign airborne    = (st_q != ST_GROUND);

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Directed bench for char_motion_ctrl: vector table plus hand sequences for clamps, respawn and grace jumps.
// Inputs change on the falling edge; outputs are sampled on the falling edge after the updating rising edge.
// Input vectors are packed as {tick, left, right, jump, coll_up, coll_down, coll_left, coll_right}.
module tb_char_motion_ctrl;

    localparam logic [1:0] G  = 2'b00;
    localparam logic [1:0] RS = 2'b01;
    localparam logic [1:0] FL = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       move_left = 1'b0;
    logic       move_right = 1'b0;
    logic       jump = 1'b0;
    logic       coll_up = 1'b0;
    logic       coll_down = 1'b0;
    logic       coll_left = 1'b0;
    logic       coll_right = 1'b0;
    logic       respawn = 1'b0;
    logic [9:0] x_pos;
    logic [8:0] y_pos;
    logic signed [8:0] v_speed;
    logic [1:0] state;
    logic       facing_left;
    logic       walking;
    logic       airborne;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    char_motion_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .move_left  (move_left),
        .move_right (move_right),
        .jump       (jump),
        .coll_up    (coll_up),
        .coll_down  (coll_down),
        .coll_left  (coll_left),
        .coll_right (coll_right),
        .respawn    (respawn),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .v_speed    (v_speed),
        .state      (state),
        .facing_left(facing_left),
        .walking    (walking),
        .airborne   (airborne)
    );

    typedef struct {
        logic [7:0] in;
        int         ex;
        int         ey;
        int         ev;
        logic [1:0] est;
        logic       ef;
        logic       ew;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] in, input int ex, input int ey, input int ev,
                                input logic [1:0] est, input logic ef, input logic ew);
        vec_t r;
        r.in = in; r.ex = ex; r.ey = ey; r.ev = ev; r.est = est; r.ef = ef; r.ew = ew;
        return r;
    endfunction

    task automatic drive(input logic [7:0] in, input logic rsp);
        @(negedge clk);
        {frame_tick, move_left, move_right, jump, coll_up, coll_down, coll_left, coll_right} = in;
        respawn = rsp;
        @(negedge clk);
        frame_tick = 1'b0;
        respawn    = 1'b0;
    endtask

    task automatic check(input string nm, input int ex, input int ey, input int ev,
                         input logic [1:0] est, input logic ef, input logic ew);
        logic [9:0] wx;
        logic [8:0] wy;
        logic [8:0] wv;
        logic       ok;
        wx = ex[9:0];
        wy = ey[8:0];
        wv = ev[8:0];
        checks++;
        ok = (x_pos === wx) && (y_pos === wy) && (v_speed === wv) && (state === est) &&
             (facing_left === ef) && (walking === ew) && (airborne === (est != G));
        if (!ok) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d v=%0d st=%b face=%b walk=%b air=%b, want x=%0d y=%0d v=%0d st=%b face=%b walk=%b air=%b",
                     nm, x_pos, y_pos, v_speed, state, facing_left, walking, airborne,
                     ex, ey, ev, est, ef, ew, (est != G));
        end
    endtask

    initial begin
        // Reset -> land -> walk-off free fall while walking right.
        tbl.push_back(mk(8'b1000_0100,  0,   0,   0, G,  0, 0));
        tbl.push_back(mk(8'b0010_0100,  0,   0,   0, G,  0, 0));   // no tick: hold
        tbl.push_back(mk(8'b1000_0000,  0,   0,   0, FL, 0, 0));   // walk off
        for (int k = 1; k <= 14; k++)
            tbl.push_back(mk(8'b1010_0000, k, k*(k+1)/2, -k, FL, 0, 1));
        tbl.push_back(mk(8'b1100_0010, 14, 119, -14, FL, 1, 0));  // terminal speed, blocked left
        tbl.push_back(mk(8'b1110_0100, 14, 119,   0, G,  1, 0));  // land, both keys
        tbl.push_back(mk(8'b1000_0100, 14, 119,   0, G,  1, 0));
        // Full-height jump from y=119: peak 14, then falls.
        tbl.push_back(mk(8'b1101_0100, 13, 105,  14, RS, 1, 1));
        tbl.push_back(mk(8'b1011_0000, 14,  92,  13, RS, 0, 1));
        for (int v = 12; v >= 1; v--)
            tbl.push_back(mk(8'b1001_0000, 14, 14 + v*(v-1)/2, v, RS, 0, 0));
        tbl.push_back(mk(8'b1001_0000, 14,  14,   0, FL, 0, 0));
        tbl.push_back(mk(8'b1001_0000, 14,  15,  -1, FL, 0, 0));
        tbl.push_back(mk(8'b1001_0100, 14,  15,   0, G,  0, 0));
        tbl.push_back(mk(8'b1001_0100, 14,  15,   0, G,  0, 0));  // held jump: no repeat
        tbl.push_back(mk(8'b1000_0100, 14,  15,   0, G,  0, 0));  // release re-arms
        tbl.push_back(mk(8'b1001_0100, 14,   1,  14, RS, 0, 0));
        tbl.push_back(mk(8'b1001_0000, 14,   0,  13, RS, 0, 0));  // top clamp
        tbl.push_back(mk(8'b1000_0000, 14,   0,   0, FL, 0, 0));  // early release
        tbl.push_back(mk(8'b1000_0000, 14,   1,  -1, FL, 0, 0));
        tbl.push_back(mk(8'b1000_0100, 14,   1,   0, G,  0, 0));
        tbl.push_back(mk(8'b1001_1100, 14,   1,   0, G,  0, 0));  // ceiling blocks launch
        tbl.push_back(mk(8'b1001_0100, 14,   0,  14, RS, 0, 0));
        tbl.push_back(mk(8'b1001_1000, 14,   0,   0, FL, 0, 0));  // head bump

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", 0, 0, 0, FL, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].in, 1'b0);
            check($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ev, tbl[i].est, tbl[i].ef, tbl[i].ew);
        end

        // Long fall to the bottom edge: clamps at Y_MAX and stays in FALL until coll_down.
        repeat (40) drive(8'b1000_0000, 1'b0);
        check("fall_469", 14, 469, -14, FL, 0, 0);
        drive(8'b1000_0000, 1'b0);
        check("ymax_clamp", 14, 479, -14, FL, 0, 0);
        drive(8'b1000_0000, 1'b0);
        check("ymax_still_fall", 14, 479, -14, FL, 0, 0);
        drive(8'b1000_0100, 1'b0);
        check("land_at_ymax", 14, 479, 0, G, 0, 0);

        // Right edge and horizontal blocking.
        repeat (625) drive(8'b1010_0100, 1'b0);
        check("walk_to_xmax", 639, 479, 0, G, 0, 1);
        drive(8'b1010_0100, 1'b0);
        check("xmax_sat", 639, 479, 0, G, 0, 0);
        drive(8'b1110_0100, 1'b0);
        check("both_keys", 639, 479, 0, G, 0, 0);
        drive(8'b1100_0110, 1'b0);
        check("coll_left", 639, 479, 0, G, 1, 0);
        drive(8'b1100_0100, 1'b0);
        check("step_left", 638, 479, 0, G, 1, 1);
        drive(8'b1010_0101, 1'b0);
        check("coll_right", 638, 479, 0, G, 0, 0);

        // Respawn, with and without a same-cycle tick.
        drive(8'b1010_0100, 1'b0);
        check("pre_respawn", 639, 479, 0, G, 0, 1);
        drive(8'b0000_0000, 1'b1);
        check("respawn_no_tick", 0, 0, 0, FL, 0, 0);
        drive(8'b1010_0100, 1'b0);
        check("post_respawn", 1, 0, 0, G, 0, 1);
        drive(8'b1010_0100, 1'b1);
        check("respawn_prio", 0, 0, 0, FL, 0, 0);

        // Walk-off then jump on fall tick 3.
        drive(8'b1000_0100, 1'b0);
        check("coy_land", 0, 0, 0, G, 0, 0);
        drive(8'b1000_0000, 1'b0);
        check("coy_walkoff", 0, 0, 0, FL, 0, 0);
        drive(8'b1000_0000, 1'b0);
        check("coy_f1", 0, 1, -1, FL, 0, 0);
        drive(8'b1000_0000, 1'b0);
        check("coy_f2", 0, 3, -2, FL, 0, 0);
        drive(8'b1001_0000, 1'b0);
`ifdef COYOTE_TIME_EN
        check("coy_f3_launch", 0, 0, 14, RS, 0, 0);
`else
        check("coy_f3_nolaunch", 0, 6, -3, FL, 0, 0);
`endif

        // Walk-off then jump on fall tick 5: too late in either build.
        drive(8'b0000_0000, 1'b1);
        drive(8'b1000_0100, 1'b0);
        drive(8'b1000_0000, 1'b0);
        repeat (4) drive(8'b1000_0000, 1'b0);
        check("coy_f4", 0, 10, -4, FL, 0, 0);
        drive(8'b1001_0000, 1'b0);
        check("coy_f5_nolaunch", 0, 15, -5, FL, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
